// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store replication and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b = rdata[7:0];
        case (offset)
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            2'd3:    lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_ext = {24'd0, lane_b};
            F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_ext = {16'd0, lane_h};
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access per instruction, runs a ready/valid request to data
// memory with an optional timeout, and returns extended load data or a fault pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   sd_q;

    logic          f3_ok, misaligned, illegal, go, accept, bad, timeout_hit;
    logic [3:0]    be_c;
    logic [31:0]   load_ext;

    always_comb begin
        if (mem_write)
            f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        illegal    = (mem_read & mem_write) | ~f3_ok | misaligned;
        // Both read and write high is not an access, but it is still reported as a fault.
        go         = (state == IDLE) & lsu_valid & (mem_read | mem_write);
        accept     = go & ~illegal;
        bad        = go & illegal;
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign stall       = (state == REQ) | accept;

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (off_q),
        .store_data (sd_q),
        .rdata      (dmem_rdata),
        .be         (be_c),
        .wdata      (dmem_wdata),
        .load_ext   (load_ext)
    );

    // Enables come from held request fields; gating keeps them 0 whenever no request is out.
    assign dmem_be = dmem_req ? be_c : 4'b0000;

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            sd_q       <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        cnt       <= '0;
                        dmem_req  <= 1'b1;
                        dmem_we   <= mem_write;
                        dmem_addr <= {addr[31:2], 2'b00};
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        sd_q      <= store_data;
                    end else if (bad) begin
                        fault     <= 1'b1;
                        load_data <= '0;
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        state      <= DONE;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        load_valid <= ~dmem_we;
                        if (!dmem_we)
                            load_data <= load_ext;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        fault     <= 1'b1;
                        load_data <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu (TIMEOUT=4) using immediate assertions.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, load_valid, fault;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int n_assert = 0;
    int n_fail   = 0;

    lsu #(.TIMEOUT(4), .TW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_valid  (lsu_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .fault      (fault),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        lsu_valid  = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    task automatic release_inputs();
        lsu_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Legal access: accept, hold for 'waits' REQ cycles without ready, complete, then idle.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                             input int waits, input logic [31:0] rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic exp_lv, input logic [31:0] exp_ld);
        drive(rd, wr, f3, a, sd);
        #1;
        check({tag, " stall@accept"}, 32'(stall), 32'd1);
        step();
        release_inputs();
        check({tag, " req"},   32'(dmem_req), 32'd1);
        check({tag, " addr"},  dmem_addr, a & ~32'h3);
        check({tag, " be"},    32'(dmem_be), 32'(exp_be));
        check({tag, " we"},    32'(dmem_we), 32'(wr));
        check({tag, " stall@req"}, 32'(stall), 32'd1);
        if (wr) check({tag, " wdata"}, dmem_wdata, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            step();
            check({tag, " req held"}, 32'(dmem_req), 32'd1);
            check({tag, " be held"},  32'(dmem_be), 32'(exp_be));
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        step();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        check({tag, " done req"},   32'(dmem_req), 32'd0);
        check({tag, " done stall"}, 32'(stall), 32'd0);
        check({tag, " load_valid"}, 32'(load_valid), 32'(exp_lv));
        check({tag, " load_data"},  load_data, exp_ld);
        check({tag, " fault"},      32'(fault), 32'd0);
        step();
        check({tag, " lv pulse"}, 32'(load_valid), 32'd0);
    endtask

    // Illegal access: no stall, no request, one-cycle fault, load_data cleared.
    task automatic do_illegal(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a);
        drive(rd, wr, f3, a, 32'h0);
        #1;
        check({tag, " stall"}, 32'(stall), 32'd0);
        step();
        release_inputs();
        check({tag, " fault"},     32'(fault), 32'd1);
        check({tag, " req"},       32'(dmem_req), 32'd0);
        check({tag, " load_data"}, load_data, 32'h0);
        step();
        check({tag, " fault pulse"}, 32'(fault), 32'd0);
        check({tag, " req after"},   32'(dmem_req), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        lsu_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        check("rst req",        32'(dmem_req), 32'd0);
        check("rst we",         32'(dmem_we), 32'd0);
        check("rst addr",       dmem_addr, 32'h0);
        check("rst wdata",      dmem_wdata, 32'h0);
        check("rst be",         32'(dmem_be), 32'd0);
        check("rst stall",      32'(stall), 32'd0);
        check("rst load_data",  load_data, 32'h0);
        check("rst load_valid", 32'(load_valid), 32'd0);
        check("rst fault",      32'(fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        do_access("lw100", 1, 0, F3_W,  32'h100, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 1, 32'hDEADBEEF);
        do_access("lb203", 1, 0, F3_B,  32'h203, 32'h0, 0, 32'h80FFFFFF, 4'b1000, 32'h0, 1, 32'hFFFFFF80);
        do_access("lbu203",1, 0, F3_BU, 32'h203, 32'h0, 0, 32'h80FFFFFF, 4'b1000, 32'h0, 1, 32'h00000080);
        do_access("sh302", 0, 1, F3_H,  32'h302, 32'h1234ABCD, 3, 32'h0, 4'b1100, 32'hABCDABCD, 0, 32'h00000080);
        do_access("lh102", 1, 0, F3_H,  32'h102, 32'h0, 1, 32'h80017FFF, 4'b1100, 32'h0, 1, 32'hFFFF8001);
        do_access("lhu100",1, 0, F3_HU, 32'h100, 32'h0, 0, 32'h8001F00D, 4'b0011, 32'h0, 1, 32'h0000F00D);
        do_access("sb201", 0, 1, F3_B,  32'h201, 32'h000000A5, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 0, 32'h0000F00D);

        do_illegal("lw101",  1, 0, F3_W,   32'h101);
        do_illegal("lh001",  1, 0, F3_H,   32'h001);
        do_illegal("f3_011", 1, 0, 3'b011, 32'h040);
        do_illegal("rd_wr",  1, 1, F3_W,   32'h040);
        do_illegal("sbu",    0, 1, F3_BU,  32'h040);

        // Ready on the 4th REQ cycle, exactly when the counter reaches TIMEOUT: success.
        do_access("lw500 edge", 1, 0, F3_W, 32'h500, 32'h0, 3, 32'h13579BDF, 4'b1111, 32'h0, 1, 32'h13579BDF);

        // Ready never arrives: request dropped and fault after 4 REQ cycles.
        drive(1, 0, F3_W, 32'h400, 32'h0);
        step();
        release_inputs();
        check("to req c1", 32'(dmem_req), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            check("to req held", 32'(dmem_req), 32'd1);
            check("to no fault", 32'(fault), 32'd0);
        end
        step();
        check("to fault",     32'(fault), 32'd1);
        check("to req drop",  32'(dmem_req), 32'd0);
        check("to stall",     32'(stall), 32'd0);
        check("to load_data", load_data, 32'h0);
        step();
        check("to fault pulse", 32'(fault), 32'd0);

        // Asynchronous reset in the middle of REQ.
        drive(1, 0, F3_W, 32'h600, 32'h0);
        step();
        release_inputs();
        check("rstmid req before",   32'(dmem_req), 32'd1);
        check("rstmid stall before", 32'(stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid req async",   32'(dmem_req), 32'd0);
        check("rstmid stall async", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        do_access("lw700 post-rst", 1, 0, F3_W, 32'h700, 32'h0, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 1, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
